// File: rtl/nios_dbg_pkg.sv
// Shared defaults and helpers for the Nios II debug bridge, system-clock side.
package nios_dbg_pkg;

   localparam int NIOS_DBG_DATA_W  = 38;
   localparam int NIOS_DBG_IR_W    = 2;
   localparam int NIOS_DBG_ACT_BIT = 34;

   // A queue entry carries the instruction on top of the DR word.
   function automatic int entry_w(input int data_w, input int ir_w);
      return data_w + ir_w;
   endfunction

endpackage

// File: rtl/nios_dbg_cmd_fifo.sv
// Synchronous command FIFO with a registered head entry. Pointers carry one
// extra wrap bit so full and empty are distinguishable.
module nios_dbg_cmd_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      rd_ptr_nxt;
   logic             wr_en;
   logic             rd_en;

   assign level      = wr_ptr - rd_ptr;
   assign empty      = (level == '0);
   assign full       = level[AW];
   assign rd_en      = pop & ~empty;
   assign wr_en      = push & (~full | rd_en);
   assign rd_ptr_nxt = rd_ptr + PTR_ONE;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= din;
   end

   // Head is refilled from the next slot, or straight from din when the
   // entry being written is the only one left.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head   <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) begin
            rd_ptr <= rd_ptr_nxt;
            if (level > PTR_ONE)
               head <= mem[rd_ptr_nxt[AW-1:0]];
            else if (wr_en)
               head <= din;
         end else if (empty && wr_en) begin
            head <= din;
         end
      end
   end

endmodule

// File: rtl/nios_dbg_sysclk_cmd_queue.sv
// System-clock side of the Nios II JTAG debug bridge: synchronises update
// strobes, queues completed DR scans and issues per-instruction strobes.
module nios_dbg_sysclk_cmd_queue
   import nios_dbg_pkg::*;
#(
   parameter int DATA_W      = NIOS_DBG_DATA_W,
   parameter int IR_W        = NIOS_DBG_IR_W,
   parameter int ACT_BIT     = NIOS_DBG_ACT_BIT,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [DATA_W-1:0]          sr,
   input  logic [IR_W-1:0]            ir_in,
   input  logic                       vs_uir,
   input  logic                       vs_udr,
   input  logic                       cmd_ready,
   input  logic                       clear_overflow,
   output logic                       cmd_valid,
   output logic [IR_W-1:0]            cmd_ir,
   output logic [DATA_W-1:0]          jdo,
   output logic [(2**IR_W)-1:0]       take_action,
   output logic [(2**IR_W)-1:0]       take_no_action,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow
);

   localparam int ENT_W = entry_w(DATA_W, IR_W);

   logic [SYNC_STAGES-1:0] uir_sync;
   logic [SYNC_STAGES-1:0] udr_sync;
   logic                   uir_hist;
   logic                   udr_hist;
   logic                   uir_edge;
   logic                   udr_edge;
   logic [IR_W-1:0]        ir_latched;
   logic [IR_W-1:0]        push_ir;
   logic [ENT_W-1:0]       fifo_din;
   logic [ENT_W-1:0]       head;
   logic [DATA_W-1:0]      head_data;
   logic                   full;
   logic                   empty;
   logic                   pop;
   logic                   drop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uir_sync   <= '0;
         udr_sync   <= '0;
         uir_hist   <= 1'b0;
         udr_hist   <= 1'b0;
         ir_latched <= '0;
      end else begin
         uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
         udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         uir_hist <= uir_sync[SYNC_STAGES-1];
         udr_hist <= udr_sync[SYNC_STAGES-1];
         if (uir_edge)
            ir_latched <= ir_in;
      end
   end

   assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_hist;
   assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_hist;

   // A coincident IR update must tag this DR scan, so bypass ir_latched.
   assign push_ir  = uir_edge ? ir_in : ir_latched;
   assign fifo_din = {push_ir, sr};

   assign cmd_valid = ~empty;
   assign pop       = cmd_valid & cmd_ready;
   assign drop      = udr_edge & full & ~pop;
   assign cmd_ir    = head[ENT_W-1:DATA_W];
   assign head_data = head[DATA_W-1:0];

   nios_dbg_cmd_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (udr_edge),
      .pop     (pop),
      .din     (fifo_din),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   // Output stage: strobes default low every cycle, so each pop is one pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jdo            <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         overflow       <= 1'b0;
      end else begin
         take_action    <= '0;
         take_no_action <= '0;
         if (pop) begin
            jdo <= head_data;
            if (head_data[ACT_BIT])
               take_action[cmd_ir] <= 1'b1;
            else
               take_no_action[cmd_ir] <= 1'b1;
         end
         if (drop)
            overflow <= 1'b1;
         else if (clear_overflow)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nios_dbg_sysclk_cmd_queue.sv
// Scoreboard bench for the debug command queue: scans push expectations,
// a negedge monitor pops and compares every strobe pulse.
module tb_nios_dbg_sysclk_cmd_queue;

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] sr;
   logic [1:0]  ir_in;
   logic        vs_uir;
   logic        vs_udr;
   logic        cmd_ready;
   logic        clear_overflow;
   logic        cmd_valid;
   logic [1:0]  cmd_ir;
   logic [37:0] jdo;
   logic [3:0]  take_action;
   logic [3:0]  take_no_action;
   logic [2:0]  level;
   logic        overflow;

   ent_t        sb[$];
   logic [1:0]  cur_ir;
   int          chk_cnt  = 0;
   int          pass_cnt = 0;

   nios_dbg_sysclk_cmd_queue dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sr             (sr),
      .ir_in          (ir_in),
      .vs_uir         (vs_uir),
      .vs_udr         (vs_udr),
      .cmd_ready      (cmd_ready),
      .clear_overflow (clear_overflow),
      .cmd_valid      (cmd_valid),
      .cmd_ir         (cmd_ir),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .level          (level),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   // Every strobe pulse must match the oldest outstanding scan.
   always @(negedge clk) begin
      if (reset_n && (take_action != 4'b0 || take_no_action != 4'b0)) begin
         chk_cnt++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected_pulse act=%b nact=%b jdo=%h", take_action, take_no_action, jdo);
         end else begin
            ent_t       e;
            logic [3:0] ea;
            logic [3:0] en;
            e  = sb.pop_front();
            ea = e.data[34] ? (4'b0001 << e.ir) : 4'b0000;
            en = e.data[34] ? 4'b0000 : (4'b0001 << e.ir);
            if (jdo === e.data && take_action === ea && take_no_action === en)
               pass_cnt++;
            else
               $display("FAIL sb_pop got jdo=%h act=%b nact=%b want jdo=%h act=%b nact=%b",
                        jdo, take_action, take_no_action, e.data, ea, en);
         end
      end
   end

   task automatic ir_scan(input logic [1:0] ir);
      @(negedge clk);
      ir_in  = ir;
      vs_uir = 1'b1;
      repeat (4) @(negedge clk);
      vs_uir = 1'b0;
      repeat (4) @(negedge clk);
      cur_ir = ir;
   endtask

   task automatic dr_scan(input logic [37:0] d, input bit keep);
      @(negedge clk);
      sr     = d;
      vs_udr = 1'b1;
      if (keep) sb.push_back('{ir: cur_ir, data: d});
      repeat (4) @(negedge clk);
      vs_udr = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({cmd_valid, cmd_ir, jdo, take_action, take_no_action, level, overflow} !== '0)
         $display("FAIL reset_outputs got v=%b ir=%0d jdo=%h a=%b n=%b lvl=%0d ovf=%b want all 0",
                  cmd_valid, cmd_ir, jdo, take_action, take_no_action, level, overflow);
      else pass_cnt++;
      reset_n = 1'b1;
      cur_ir  = 2'd0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      ir_scan(2'd2);
      cmd_ready = 1'b1;
      @(negedge clk);
      sr     = 38'h04_0000_1234;
      vs_udr = 1'b1;
      sb.push_back('{ir: 2'd2, data: 38'h04_0000_1234});
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (cmd_valid !== 1'b0) $display("FAIL basic_valid_early got %b want 0", cmd_valid);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (cmd_valid !== 1'b1 || level !== 3'd1)
         $display("FAIL basic_valid_latency got v=%b lvl=%0d want v=1 lvl=1", cmd_valid, level);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (take_action !== 4'b0100 || jdo !== 38'h04_0000_1234 || cmd_valid !== 1'b0)
         $display("FAIL basic_pop got a=%b jdo=%h v=%b want a=0100 jdo=0400001234 v=0",
                  take_action, jdo, cmd_valid);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (take_action !== 4'b0000 || jdo !== 38'h04_0000_1234)
         $display("FAIL basic_pulse_width got a=%b jdo=%h want a=0000 jdo held", take_action, jdo);
      else pass_cnt++;
      vs_udr = 1'b0;
      repeat (4) @(negedge clk);
      cmd_ready = 1'b0;
   endtask

   task automatic test_overflow;
      ir_scan(2'd0);
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         dr_scan(38'h00_0000_0100 + 38'(i), i < 4);
      chk_cnt++;
      if (level !== 3'd4 || overflow !== 1'b1)
         $display("FAIL ovf_full got lvl=%0d ovf=%b want lvl=4 ovf=1", level, overflow);
      else pass_cnt++;
      @(negedge clk);
      cmd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk_cnt++;
         if (take_no_action !== 4'b0001 || take_action !== 4'b0000)
            $display("FAIL ovf_drain_pulse%0d got n=%b a=%b want n=0001 a=0000",
                     k, take_no_action, take_action);
         else pass_cnt++;
      end
      @(negedge clk);
      cmd_ready = 1'b0;
      chk_cnt++;
      if (take_no_action !== 4'b0000 || level !== 3'd0 || cmd_valid !== 1'b0)
         $display("FAIL ovf_drained got n=%b lvl=%0d v=%b want 0/0/0", take_no_action, level, cmd_valid);
      else pass_cnt++;
      clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      chk_cnt++;
      if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow);
      else pass_cnt++;
   endtask

   task automatic test_same_cycle;
      ir_scan(2'd1);
      cmd_ready = 1'b1;
      @(negedge clk);
      ir_in  = 2'd3;
      sr     = 38'h04_ABCD_0001;
      vs_uir = 1'b1;
      vs_udr = 1'b1;
      sb.push_back('{ir: 2'd3, data: 38'h04_ABCD_0001});
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (cmd_valid !== 1'b1 || cmd_ir !== 2'd3)
         $display("FAIL same_cycle_ir got v=%b ir=%0d want v=1 ir=3", cmd_valid, cmd_ir);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (take_action !== 4'b1000) $display("FAIL same_cycle_strobe got a=%b want 1000", take_action);
      else pass_cnt++;
      vs_uir = 1'b0;
      vs_udr = 1'b0;
      repeat (4) @(negedge clk);
      cur_ir    = 2'd3;
      cmd_ready = 1'b0;
   endtask

   task automatic test_full_with_pop;
      cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         dr_scan({(i % 2 == 0), 34'h0_0000_0200 + 34'(i)}, 1'b1);
      chk_cnt++;
      if (level !== 3'd4) $display("FAIL fullpop_fill got lvl=%0d want 4", level);
      else pass_cnt++;
      @(negedge clk);
      sr     = 38'h04_0000_0FFF;
      vs_udr = 1'b1;
      sb.push_back('{ir: cur_ir, data: 38'h04_0000_0FFF});
      repeat (2) @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      chk_cnt++;
      if (level !== 3'd4 || overflow !== 1'b0)
         $display("FAIL fullpop_level got lvl=%0d ovf=%b want lvl=4 ovf=0", level, overflow);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      vs_udr = 1'b0;
      repeat (4) @(negedge clk);
      cmd_ready = 1'b1;
      repeat (6) @(negedge clk);
      cmd_ready = 1'b0;
      chk_cnt++;
      if (level !== 3'd0) $display("FAIL fullpop_drain got lvl=%0d want 0", level);
      else pass_cnt++;
   endtask

   task automatic test_reset_midop;
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         dr_scan(38'h04_0000_0300 + 38'(i), i < 4);
      @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      #2;
      chk_cnt++;
      if (level !== 3'd3 || take_action === 4'b0000 || overflow !== 1'b1)
         $display("FAIL midop_setup got lvl=%0d a=%b ovf=%b want lvl=3 strobe ovf=1",
                  level, take_action, overflow);
      else pass_cnt++;
      reset_n = 1'b0;
      #1;
      chk_cnt++;
      if ({cmd_valid, cmd_ir, jdo, take_action, take_no_action, level, overflow} !== '0)
         $display("FAIL midop_reset got v=%b ir=%0d jdo=%h a=%b n=%b lvl=%0d ovf=%b want all 0",
                  cmd_valid, cmd_ir, jdo, take_action, take_no_action, level, overflow);
      else pass_cnt++;
      sb.delete();
      cur_ir = 2'd0;
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      cmd_ready = 1'b1;
      dr_scan(38'h04_5555_0001, 1'b1);
      chk_cnt++;
      if (sb.size() != 0 || level !== 3'd0 || jdo !== 38'h04_5555_0001)
         $display("FAIL midop_first_after got pending=%0d lvl=%0d jdo=%h want 0/0/0455550001",
                  sb.size(), level, jdo);
      else pass_cnt++;
      cmd_ready = 1'b0;
   endtask

   task automatic test_long_hold;
      cmd_ready = 1'b0;
      @(negedge clk);
      sr     = 38'h00_0000_0777;
      vs_udr = 1'b1;
      sb.push_back('{ir: cur_ir, data: 38'h00_0000_0777});
      repeat (20) @(negedge clk);
      chk_cnt++;
      if (level !== 3'd1) $display("FAIL hold_level got %0d want 1", level);
      else pass_cnt++;
      vs_udr = 1'b0;
      repeat (4) @(negedge clk);
      cmd_ready = 1'b1;
      repeat (3) @(negedge clk);
      cmd_ready = 1'b0;
      chk_cnt++;
      if (level !== 3'd0) $display("FAIL hold_drain got %0d want 0", level);
      else pass_cnt++;
   endtask

   initial begin
      reset_n        = 1'b0;
      sr             = '0;
      ir_in          = '0;
      vs_uir         = 1'b0;
      vs_udr         = 1'b0;
      cmd_ready      = 1'b0;
      clear_overflow = 1'b0;
      cur_ir         = '0;
      test_reset();
      test_basic();
      test_overflow();
      test_same_cycle();
      test_full_with_pop();
      test_reset_midop();
      test_long_hold();
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (sb.size() != 0) $display("FAIL sb_leftover got %0d pending want 0", sb.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/nios_dbg_sysclk_cmd_queue.md
# nios_dbg_sysclk_cmd_queue

Parametrised system-clock side of the Nios II JTAG debug bridge. It synchronises the virtual-JTAG update-IR and update-DR strobes into `clk` and captures each completed DR scan (instruction plus shift-register word) into a small command queue. It pops commands under a valid/ready handshake and issues one-cycle, per-instruction `take_action` / `take_no_action` strobes with the matching `jdo` word. It sits between the TCK-domain shift logic and the OCI memory, break and trace controllers. It replaces the fixed 2-bit-IR, 38-bit, unbuffered decoder.

## Interface
Parameters:
- `DATA_W`, 38: width of `sr` / `jdo`.
- `IR_W`, 2: instruction-register width; number of instructions is `2**IR_W`.
- `ACT_BIT`, 34: `jdo` bit that selects action (1) or no-action (0); must be < `DATA_W`.
- `SYNC_STAGES`, 2: synchroniser depth for `vs_uir` / `vs_udr`; must be ≥ 2.
- `DEPTH`, 4: command queue depth; must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sr`  in  `DATA_W`  TCK-domain DR word; stable while `vs_udr` is high.
- `ir_in`  in  `IR_W`  TCK-domain instruction; stable while `vs_uir` is high.
- `vs_uir`  in  1  update-IR level from the JTAG domain (async).
- `vs_udr`  in  1  update-DR level from the JTAG domain (async).
- `cmd_ready`  in  1  consumer may accept the head command.
- `clear_overflow`  in  1  clears `overflow`.
- `cmd_valid`  out  1  queue is non-empty.
- `cmd_ir`  out  `IR_W`  instruction of the head entry.
- `jdo`  out  `DATA_W`  data of the last popped command; held until the next pop.
- `take_action`  out  `2**IR_W`  one-hot pulse, index = popped IR, popped `jdo[ACT_BIT]`=1.
- `take_no_action`  out  `2**IR_W`  one-hot pulse, index = popped IR, popped `jdo[ACT_BIT]`=0.
- `level`  out  `$clog2(DEPTH)+1`  current number of queued entries.
- `overflow`  out  1  sticky; set when a capture is dropped.

## Operation
- Synchronise `vs_uir` and `vs_udr` through `SYNC_STAGES` flops each, then a history flop.
- `uir_edge` = sync_out & ~hist. `udr_edge` is formed the same way. Both are combinational and valid for one cycle.
- On `uir_edge`, `ir_latched` ← `ir_in`.
- On `udr_edge`, push the entry {`uir_edge` ? `ir_in` : `ir_latched`, `sr`}. When both edges occur in the same cycle, the new IR is used.
- Push while full (and no pop in the same cycle): the entry is dropped and `overflow` is set to 1. Existing entries are untouched.
- Pop = `cmd_valid` & `cmd_ready`. On the pop edge:
  - `jdo` ← head data.
  - Exactly one bit of `take_action` or `take_no_action` is set, for one cycle.
  - Otherwise both vectors are 0.
- Push and pop in the same cycle:
  - Allowed at any level, including full; the level is unchanged and there is no overflow.
  - When empty, there is no bypass: the pushed entry becomes the head next cycle.
- `clear_overflow` clears `overflow`. If it coincides with a dropping push, the set wins.
- `ir_latched` wraps nothing; the FIFO pointers wrap modulo `DEPTH`, with an extra bit to distinguish full from empty.
- Reset values:
  - All sync and history flops 0; `ir_latched` 0; queue empty.
  - `cmd_valid` 0, `cmd_ir` 0, `jdo` 0, both strobe vectors 0, `level` 0, `overflow` 0.
- Reset mid-operation discards all queued entries, and any pulse in flight is cut immediately.

## Timing
- Capture latency: if `vs_udr` is first sampled high at edge N, the entry is written at edge N+`SYNC_STAGES`. With an empty queue, `cmd_valid` is 1 after that edge.
- Pop latency: a pop at edge M gives `jdo`, `take_*` and the updated `cmd_valid` / `cmd_ir` / `level` after edge M. The strobes fall after edge M+1.
- Throughput: one pop per cycle. Captures are limited by the JTAG scan rate.
- Each `vs_udr` high phase yields exactly one push, however long it is held. Minimum input low time is `SYNC_STAGES`+1 `clk` periods.
- `cmd_ir` and the head data are registered outputs, not FIFO combinational reads.

## Structure
- Package `nios_dbg_pkg` holds:
  - Default localparams `NIOS_DBG_DATA_W`, `NIOS_DBG_IR_W`, `NIOS_DBG_ACT_BIT`.
  - Function `entry_w(data_w, ir_w)` = data_w + ir_w.
- Sub-module `nios_dbg_cmd_fifo`: synchronous FIFO with `WIDTH` and `DEPTH` parameters, providing push, pop, full, empty, level and a registered head. It has no overflow logic; drop and sticky handling stay in the parent.
- The synchroniser and edge detect are inline; there is no separate module.

## Test plan
- Reset, then IR scan `ir_in`=2 followed by a DR scan with `sr`=38'h04_0000_1234 and `cmd_ready`=1:
  - `cmd_valid` rises 2 edges after `vs_udr` is sampled.
  - Pop gives `jdo`=38'h04_0000_1234 and `take_action`=4'b0100 for 1 cycle.
- Five DR scans with `ir_in`=0 and `jdo[34]`=0, `cmd_ready`=0, `DEPTH`=4:
  - `level`=4 and `overflow`=1.
  - Releasing `cmd_ready` gives 4 `take_no_action`=4'b0001 pulses on consecutive cycles, with the data of the first four scans in order.
- `vs_uir` and `vs_udr` rise in the same cycle with `ir_in`=3: the entry carries IR 3, not the old latched IR 1.
- Queue full and `cmd_ready`=1 when a new `udr_edge` arrives: `level` stays 4, `overflow` stays 0, and the FIFO order is preserved.
- `reset_n` asserted while `level`=3 and a strobe is high:
  - All outputs are 0 immediately and `overflow` is 0.
  - After release, the first new scan is the first entry out.
- `vs_udr` held high for 20 cycles: exactly 1 push and `level`=1.
